// File: rtl/writeback_stage.sv
// writeback_stage: retire stage with load align/extend, misalign and timeout detection (optional WB_RETIRE_CNT_EN retire counter)
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic        WB_CLK,
    input  logic        WB_RST_N,
    input  logic        MEM_VALID,
    output logic        WB_READY,
    input  logic [31:0] MEM_ALU_RESULT,
    input  logic [31:0] MEM_PC_PLUS4,
    input  logic [1:0]  MEM_RF_WR_SEL,
    input  logic        MEM_REG_WRITE,
    input  logic [4:0]  MEM_RD_ADDR,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_UNSIGNED,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_RVALID,
    output logic        RF_WE,
    output logic [4:0]  RF_WA,
    output logic [31:0] RF_WD,
    output logic        LOAD_MISALIGN,
    output logic        LOAD_ERR,
    output logic [31:0] RETIRE_CNT
);
    typedef enum logic {IDLE, LOAD_WAIT} state_t;
    localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);
    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [4:0]  ld_rd;
    logic        ld_we, ld_uns;
    logic [1:0]  ld_size, ld_off;
    logic        xfer, is_load, misalign, accept_load, timeout, load_done;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data, alu_data;
    assign WB_READY = state == IDLE;
    // handshake decode, misalign/timeout detection and next state
    always_comb begin
        state_nx    = state;
        xfer        = MEM_VALID & (state == IDLE);
        is_load     = MEM_RF_WR_SEL == 2'd1;
        misalign    = ((MEM_SIZE == 2'd1) & MEM_ALU_RESULT[0]) | (MEM_SIZE[1] & |MEM_ALU_RESULT[1:0]);
        accept_load = xfer & is_load & ~misalign;
        load_done   = (state == LOAD_WAIT) & DMEM_RVALID;
        timeout     = (state == LOAD_WAIT) & ~DMEM_RVALID & (cnt == TO_LAST);
        if (accept_load) state_nx = LOAD_WAIT;
        if (load_done | timeout) state_nx = IDLE;
    end
    // little-endian lane select and sign/zero extension of the returned word
    always_comb begin
        byte_sel  = ld_off[1] ? (ld_off[0] ? DMEM_RDATA[31:24] : DMEM_RDATA[23:16])
                              : (ld_off[0] ? DMEM_RDATA[15:8] : DMEM_RDATA[7:0]);
        half_sel  = ld_off[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
        load_data = (ld_size == 2'd0) ? {{24{~ld_uns & byte_sel[7]}}, byte_sel}
                  : (ld_size == 2'd1) ? {{16{~ld_uns & half_sel[15]}}, half_sel} : DMEM_RDATA;
        alu_data  = (MEM_RF_WR_SEL == 2'd2) ? MEM_PC_PLUS4 : MEM_ALU_RESULT;
    end
    // state register
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) state <= IDLE;
        else state <= state_nx;
    end
    // pending-load context and timeout counter
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            cnt     <= '0;
            ld_rd   <= '0;
            ld_we   <= 1'b0;
            ld_size <= '0;
            ld_uns  <= 1'b0;
            ld_off  <= '0;
        end else if (accept_load) begin
            cnt     <= '0;
            ld_rd   <= MEM_RD_ADDR;
            ld_we   <= MEM_REG_WRITE;
            ld_size <= MEM_SIZE;
            ld_uns  <= MEM_UNSIGNED;
            ld_off  <= MEM_ALU_RESULT[1:0];
        end else if ((state == LOAD_WAIT) & ~DMEM_RVALID) begin
            cnt <= cnt + 8'd1;
        end
    end
    // registered register-file write and single-cycle status pulses
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            RF_WE         <= 1'b0;
            RF_WA         <= '0;
            RF_WD         <= '0;
            LOAD_MISALIGN <= 1'b0;
            LOAD_ERR      <= 1'b0;
        end else begin
            RF_WE         <= 1'b0;
            LOAD_MISALIGN <= xfer & is_load & misalign;
            LOAD_ERR      <= timeout;
            if (xfer & ~is_load) begin
                RF_WE <= MEM_REG_WRITE & |MEM_RD_ADDR;
                RF_WA <= MEM_RD_ADDR;
                RF_WD <= alu_data;
            end else if (load_done) begin
                RF_WE <= ld_we & |ld_rd;
                RF_WA <= ld_rd;
                RF_WD <= load_data;
            end
        end
    end
`ifdef WB_RETIRE_CNT_EN
    logic done;
    assign done = (xfer & (~is_load | misalign)) | load_done | timeout;
    // count every completing instruction, wrapping naturally
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) RETIRE_CNT <= '0;
        else if (done) RETIRE_CNT <= RETIRE_CNT + 32'd1;
    end
`else
    assign RETIRE_CNT = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus with a queued scoreboard checked by an output monitor
module tb_writeback_stage;
    logic        WB_CLK = 0, WB_RST_N = 0;
    logic        MEM_VALID = 0, MEM_REG_WRITE = 0, MEM_UNSIGNED = 0, DMEM_RVALID = 0;
    logic [31:0] MEM_ALU_RESULT = 0, MEM_PC_PLUS4 = 0, DMEM_RDATA = 0;
    logic [1:0]  MEM_RF_WR_SEL = 0, MEM_SIZE = 0;
    logic [4:0]  MEM_RD_ADDR = 0;
    logic        WB_READY, RF_WE, LOAD_MISALIGN, LOAD_ERR;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD, RETIRE_CNT;

    writeback_stage #(.LOAD_TIMEOUT(16)) dut (
        .WB_CLK(WB_CLK), .WB_RST_N(WB_RST_N), .MEM_VALID(MEM_VALID), .WB_READY(WB_READY),
        .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_PC_PLUS4(MEM_PC_PLUS4), .MEM_RF_WR_SEL(MEM_RF_WR_SEL),
        .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_SIZE(MEM_SIZE),
        .MEM_UNSIGNED(MEM_UNSIGNED), .DMEM_RDATA(DMEM_RDATA), .DMEM_RVALID(DMEM_RVALID),
        .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD), .LOAD_MISALIGN(LOAD_MISALIGN),
        .LOAD_ERR(LOAD_ERR), .RETIRE_CNT(RETIRE_CNT)
    );

    always #5 WB_CLK = ~WB_CLK;

    typedef struct {
        logic [2:0]  kind;
        int          due;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;
    localparam logic [2:0] K_WR = 3'b001, K_MIS = 3'b010, K_ERR = 3'b100;

    exp_t q[$];
    exp_t e;
    int   cyc = 0, n_cmp = 0, n_bad = 0;
    logic [31:0] exp_ret = 0;

    always @(posedge WB_CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_rc();
`ifdef WB_RETIRE_CNT_EN
        return exp_ret;
`else
        return 32'h0;
`endif
    endfunction

    always @(negedge WB_CLK) begin
        if (WB_RST_N && (RF_WE || LOAD_MISALIGN || LOAD_ERR)) begin
            if (q.size() == 0) chk("unexpected_output", {29'b0, LOAD_ERR, LOAD_MISALIGN, RF_WE}, 32'h0);
            else begin
                e = q.pop_front();
                chk("out_kind", {29'b0, LOAD_ERR, LOAD_MISALIGN, RF_WE}, {29'b0, e.kind});
                chk("out_cycle", 32'(cyc), 32'(e.due));
                if (e.kind == K_WR) begin
                    chk("rf_wa", {27'b0, RF_WA}, {27'b0, e.wa});
                    chk("rf_wd", RF_WD, e.wd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge WB_CLK);
        #1;
    endtask

    task automatic push(input logic [2:0] k, input int due, input logic [4:0] wa, input logic [31:0] wd);
        exp_t x;
        x.kind = k; x.due = due; x.wa = wa; x.wd = wd;
        q.push_back(x);
    endtask

    task automatic issue(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [1:0] sz, input logic uns);
        chk("ready_before_issue", {31'b0, WB_READY}, 32'h1);
        MEM_VALID = 1; MEM_RF_WR_SEL = sel; MEM_REG_WRITE = we; MEM_RD_ADDR = rd;
        MEM_ALU_RESULT = alu; MEM_PC_PLUS4 = pc4; MEM_SIZE = sz; MEM_UNSIGNED = uns;
        tick();
        MEM_VALID = 0;
    endtask

    task automatic alu_op(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] expwd);
        if (we && rd != 0) push(K_WR, cyc + 1, rd, expwd);
        exp_ret++;
        issue(sel, we, rd, alu, pc4, 2'd0, 1'b0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input int wait_n, input logic [31:0] rdata,
                        input logic [31:0] expwd);
        issue(2'd1, 1'b1, rd, addr, 32'h0, sz, uns);
        for (int i = 0; i < wait_n - 1; i++) begin
            chk("ready_in_load_wait", {31'b0, WB_READY}, 32'h0);
            tick();
        end
        chk("ready_in_load_wait", {31'b0, WB_READY}, 32'h0);
        DMEM_RVALID = 1; DMEM_RDATA = rdata;
        push(K_WR, cyc + 1, rd, expwd);
        exp_ret++;
        tick();
        DMEM_RVALID = 0;
        chk("ready_after_load", {31'b0, WB_READY}, 32'h1);
    endtask

    task automatic misload(input logic [31:0] addr, input logic [1:0] sz);
        push(K_MIS, cyc + 1, 5'd0, 32'h0);
        exp_ret++;
        issue(2'd1, 1'b1, 5'd3, addr, 32'h0, sz, 1'b0);
        chk("ready_after_misalign", {31'b0, WB_READY}, 32'h1);
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'b0, WB_READY}, 32'h1);
        chk("rst_outputs", {29'b0, RF_WE, LOAD_MISALIGN, LOAD_ERR}, 32'h0);
        chk("rst_rf_wa", {27'b0, RF_WA}, 32'h0);
        chk("rst_rf_wd", RF_WD, 32'h0);
        chk("rst_retire", RETIRE_CNT, 32'h0);
        @(posedge WB_CLK); #1;
        WB_RST_N = 1;
        tick();
        alu_op(2'd0, 1, 5'd5, 32'h1234_5678, 32'h0, 32'h1234_5678);
        chk("ready_after_alu", {31'b0, WB_READY}, 32'h1);
        alu_op(2'd0, 1, 5'd6, 32'hA5A5_0001, 32'h0, 32'hA5A5_0001);
        alu_op(2'd3, 1, 5'd7, 32'h0000_0777, 32'h9, 32'h0000_0777);
        alu_op(2'd0, 0, 5'd14, 32'h5555_5555, 32'h0, 32'h0);
        tick();
        load(32'h103, 2'd0, 1'b0, 5'd8, 3, 32'h80FF_FFFF, 32'hFFFF_FF80);
        load(32'h102, 2'd1, 1'b1, 5'd9, 1, 32'hBEEF_0000, 32'h0000_BEEF);
        misload(32'h101, 2'd2);
        load(32'h100, 2'd1, 1'b0, 5'd10, 1, 32'h1234_8001, 32'hFFFF_8001);
        load(32'h201, 2'd0, 1'b1, 5'd11, 2, 32'h0000_9A00, 32'h0000_009A);
        load(32'h200, 2'd2, 1'b0, 5'd12, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        misload(32'h103, 2'd1);
        misload(32'h002, 2'd3);
        DMEM_RVALID = 1; DMEM_RDATA = 32'hFFFF_FFFF;
        tick(); tick();
        DMEM_RVALID = 0;
        chk("retire_mid", RETIRE_CNT, exp_rc());
        load(32'h300, 2'd2, 1'b0, 5'd13, 16, 32'hCAFE_F00D, 32'hCAFE_F00D);
        issue(2'd1, 1'b1, 5'd15, 32'h400, 32'h0, 2'd2, 1'b0);
        push(K_ERR, cyc + 16, 5'd0, 32'h0);
        exp_ret++;
        for (int i = 0; i < 16; i++) begin
            chk("ready_before_timeout", {31'b0, WB_READY}, 32'h0);
            tick();
        end
        chk("ready_after_timeout", {31'b0, WB_READY}, 32'h1);
        alu_op(2'd2, 1, 5'd0, 32'h0, 32'h44, 32'h0);
        alu_op(2'd2, 1, 5'd1, 32'h0, 32'h44, 32'h44);
        tick();
        chk("retire_before_reset", RETIRE_CNT, exp_rc());
        issue(2'd1, 1'b1, 5'd16, 32'h500, 32'h0, 2'd2, 1'b0);
        tick();
        #2 WB_RST_N = 0;
        #1;
        exp_ret = 0;
        chk("reset_mid_load_ready", {31'b0, WB_READY}, 32'h1);
        chk("reset_mid_load_rf_wa", {27'b0, RF_WA}, 32'h0);
        chk("reset_mid_load_rf_wd", RF_WD, 32'h0);
        chk("reset_mid_load_retire", RETIRE_CNT, 32'h0);
        @(posedge WB_CLK); #1;
        WB_RST_N = 1;
        DMEM_RVALID = 1; DMEM_RDATA = 32'h1111_2222;
        tick();
        DMEM_RVALID = 0;
        tick(); tick();
        chk("ready_after_reset", {31'b0, WB_READY}, 32'h1);
        chk("retire_after_reset", RETIRE_CNT, exp_rc());
        alu_op(2'd0, 1, 5'd31, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D);
        tick(); tick();
        chk("retire_final", RETIRE_CNT, exp_rc());
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
